// File: rtl/acs_select_array.sv
// Two-stage add-compare-select back end: per-state min select with decision bits,
// followed by threshold normalisation that clears every metric MSB when all are set.
module acs_select_array #(
  parameter int WIDTH    = 8,
  parameter int N_STATES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_STATES*WIDTH-1:0]    cand0,
  input  logic [N_STATES*WIDTH-1:0]    cand1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_STATES*WIDTH-1:0]    pm_out,
  output logic [N_STATES-1:0]          dec,
  output logic                         norm
);

  logic                      advance;

  logic                      s1_valid_q, s1_valid_d;
  logic [N_STATES*WIDTH-1:0] s1_pm_q, s1_pm_d;
  logic [N_STATES-1:0]       s1_dec_q, s1_dec_d;

  logic                      out_valid_q;
  logic [N_STATES*WIDTH-1:0] pm_out_q, pm_out_d;
  logic [N_STATES-1:0]       dec_q;
  logic                      norm_q, norm_d;

  logic [N_STATES-1:0]       msb;
  logic                      allhi;

  // Both stages move together; a held output word freezes the whole pipe.
  assign advance    = ~(out_valid_q & ~out_ready);
  assign in_ready   = advance;
  assign s1_valid_d = in_valid & advance;

  genvar gi;
  generate
    for (gi = 0; gi < N_STATES; gi++) begin : g_state
      logic [WIDTH-1:0] c0;
      logic [WIDTH-1:0] c1;
      logic             sel;

      assign c0  = cand0[gi*WIDTH +: WIDTH];
      assign c1  = cand1[gi*WIDTH +: WIDTH];
      // Strict less-than so a tie keeps predecessor 0.
      assign sel = (c1 < c0);

      assign s1_pm_d[gi*WIDTH +: WIDTH] = sel ? c1 : c0;
      assign s1_dec_d[gi]               = sel;

      assign msb[gi] = s1_pm_q[gi*WIDTH + WIDTH - 1];
      assign pm_out_d[gi*WIDTH +: WIDTH] = allhi
          ? {1'b0, s1_pm_q[gi*WIDTH +: WIDTH-1]}
          : s1_pm_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign allhi  = &msb;
  assign norm_d = allhi;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_pm_q     <= '0;
      s1_dec_q    <= '0;
      out_valid_q <= 1'b0;
      pm_out_q    <= '0;
      dec_q       <= '0;
      norm_q      <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= s1_valid_d;
      s1_pm_q     <= s1_pm_d;
      s1_dec_q    <= s1_dec_d;
      out_valid_q <= s1_valid_q;
      pm_out_q    <= pm_out_d;
      dec_q       <= s1_dec_q;
      norm_q      <= norm_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pm_out    = pm_out_q;
  assign dec       = dec_q;
  assign norm      = norm_q;

endmodule

// File: tb/tb_acs_select_array.sv
// Directed bench for acs_select_array (WIDTH=8, N_STATES=4): vector table plus
// hand-written reset, backpressure, bubble and mid-stall reset sequences.
module tb_acs_select_array;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] cand0;
  logic [N*W-1:0] cand1;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] pm_out;
  logic [N-1:0]   dec;
  logic           norm;

  int total;
  int bad;

  acs_select_array #(.WIDTH(W), .N_STATES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cand0     (cand0),
    .cand1     (cand1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pm_out    (pm_out),
    .dec       (dec),
    .norm      (norm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] c0;
    logic [N*W-1:0] c1;
    logic [N*W-1:0] pm;
    logic [N-1:0]   dec;
    logic           norm;
  } vec_t;

  vec_t vecs[7];

  // State 0 goes in the least significant byte.
  function automatic logic [N*W-1:0] pk(input int s0, input int s1, input int s2, input int s3);
    logic [N*W-1:0] r;
    r = {s3[W-1:0], s2[W-1:0], s1[W-1:0], s0[W-1:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N*W-1:0] wa, wb, wc, wd;

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cand0     = pk(1, 2, 3, 4);
    cand1     = pk(0, 0, 0, 0);

    vecs[0] = '{pk(10, 20, 30, 40),    pk(15, 5, 30, 41),     pk(10, 5, 30, 40),     4'b0010, 1'b0};
    vecs[1] = '{pk(200, 130, 255, 129), pk(210, 140, 250, 128), pk(72, 2, 122, 0),    4'b1100, 1'b1};
    vecs[2] = '{pk(200, 130, 255, 129), pk(210, 140, 100, 128), pk(200, 130, 100, 128), 4'b1100, 1'b0};
    vecs[3] = '{pk(7, 7, 7, 7),         pk(7, 7, 7, 7),         pk(7, 7, 7, 7),         4'b0000, 1'b0};
    vecs[4] = '{pk(0, 0, 0, 0),         pk(0, 0, 0, 0),         pk(0, 0, 0, 0),         4'b0000, 1'b0};
    vecs[5] = '{pk(128, 128, 128, 128), pk(255, 255, 255, 255), pk(0, 0, 0, 0),         4'b0000, 1'b1};
    vecs[6] = '{pk(128, 255, 128, 200), pk(255, 127, 255, 255), pk(128, 127, 128, 200), 4'b0010, 1'b0};

    // Reset held two cycles with in_valid high.
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_pm_out", pm_out, 0);
    check("rst_dec", dec, 0);
    check("rst_norm", norm, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", in_ready, 1);
    tick();
    check("idle_out_valid", out_valid, 0);
    $display("reset: out_valid=%0b pm_out=%0h in_ready=%0b", out_valid, pm_out, in_ready);

    // Table-driven single-word transactions.
    for (int i = 0; i < 7; i++) begin
      cand0    = vecs[i].c0;
      cand1    = vecs[i].c1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("lat1_out_valid", out_valid, 0);
      tick();
      check("vec_out_valid", out_valid, 1);
      check("vec_pm_out", pm_out, vecs[i].pm);
      check("vec_dec", dec, vecs[i].dec);
      check("vec_norm", norm, vecs[i].norm);
      $display("vec %0d: pm_out=%08h dec=%04b norm=%0b", i, pm_out, dec, norm);
      tick();
    end

    // Backpressure: A reaches output, stall 3 cycles, then A,B,C in order.
    wa = pk(1, 2, 3, 4);
    wb = pk(11, 12, 13, 14);
    wc = pk(21, 22, 23, 24);
    cand1 = pk(255, 255, 255, 255);
    cand0 = wa; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    cand0 = wb;
    tick();
    check("bp_a_out_valid", out_valid, 1);
    check("bp_a_pm", pm_out, wa);
    cand0     = wc;
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_pm", pm_out, wa);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_b_valid", out_valid, 1);
    check("bp_b_pm", pm_out, wb);
    tick();
    check("bp_c_valid", out_valid, 1);
    check("bp_c_pm", pm_out, wc);
    tick();
    check("bp_drain_valid", out_valid, 0);
    $display("backpressure: A,B,C sequence complete");

    // Bubbles: in_valid 1,1,0,1 -> out_valid same pattern two edges later.
    begin
      logic [3:0] pat;
      logic       ev;
      pat = 4'b1011; // bit i drives cycle i
      for (int i = 0; i < 6; i++) begin
        if (i < 4) begin
          in_valid = pat[i];
          cand0    = pk(i + 1, i + 1, i + 1, i + 1);
        end else begin
          in_valid = 1'b0;
        end
        tick();
        ev = (i >= 1 && i <= 4) ? pat[i-1] : 1'b0;
        check("bub_out_valid", out_valid, ev);
        if (ev) check("bub_pm", pm_out, pk(i, i, i, i));
        $display("bubble cycle %0d: out_valid=%0b pm_out=%08h", i, out_valid, pm_out);
      end
    end

    // Reset while a stall holds two words.
    wd = pk(50, 60, 70, 80);
    cand0 = wa; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    cand0 = wb;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("mr_stalled_pm", pm_out, wa);
    rst = 1'b1;
    tick();
    check("mr_out_valid", out_valid, 0);
    check("mr_pm_out", pm_out, 0);
    rst = 1'b0;
    check("mr_in_ready", in_ready, 1);
    tick();
    check("mr_empty_valid", out_valid, 0);
    out_ready = 1'b1;
    cand0 = wd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mr_new_lat1", out_valid, 0);
    tick();
    check("mr_new_valid", out_valid, 1);
    check("mr_new_pm", pm_out, wd);
    $display("mid reset: new word pm_out=%08h", pm_out);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
